// File: rtl/tcdm_bfly_sched_pkg.sv
// Shared types and helpers for the butterfly TCDM priority scheduler.
package tcdm_bfly_sched_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } state_e;

  typedef enum logic {
    ROT_ON_GNT   = 1'b0,
    ROT_PERIODIC = 1'b1
  } mode_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/tcdm_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping around.
module tcdm_rr_pick import tcdm_bfly_sched_pkg::*; #(
  parameter int unsigned N = 32,
  localparam int unsigned IdxW = clog2_min1(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  // Walk offsets from the far end so the smallest offset from ptr_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = ptr_i + IdxW'(k);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/tcdm_bfly_sched.sv
// Rotating-priority driver and starvation guard in front of a butterfly TCDM network.
module tcdm_bfly_sched import tcdm_bfly_sched_pkg::*; #(
  parameter int unsigned NumIn     = 32,
  parameter int unsigned NumOut    = 32,
  parameter int unsigned WaitWidth = 8,
  parameter int unsigned PerWidth  = 16,
  localparam int unsigned RrWidth  = clog2_min1(NumOut),
  localparam int unsigned IdxWidth = clog2_min1(NumIn)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_mode_i,
  input  logic [PerWidth-1:0]  cfg_period_i,
  input  logic [WaitWidth-1:0] cfg_thresh_i,
  input  logic [NumIn-1:0]     req_i,
  output logic [NumIn-1:0]     gnt_o,
  output logic [NumIn-1:0]     req_o,
  input  logic [NumIn-1:0]     gnt_i,
  output logic [RrWidth-1:0]   rr_o,
  output logic                 starve_o,
  output logic [IdxWidth-1:0]  victim_o
);

  state_e               state_q;
  logic [RrWidth-1:0]   rr_q;
  logic [PerWidth-1:0]  per_q;
  logic [IdxWidth-1:0]  victim_q;
  logic [IdxWidth-1:0]  ptr_q;
  logic [WaitWidth-1:0] wait_q [NumIn];

  logic [NumIn-1:0]     mask;
  logic [NumIn-1:0]     starving;
  logic                 pick_valid;
  logic [IdxWidth-1:0]  pick_idx;
  logic                 rot_gnt;
  logic                 per_wrap;
  logic                 victim_done;

  // Mask depends on registered state only, so the pass-through stays glitch-safe.
  assign mask     = (state_q == STARVE) ? (NumIn'(1) << victim_q) : '1;
  assign req_o    = req_i & mask;
  assign gnt_o    = gnt_i & mask;
  assign rr_o     = rr_q;
  assign starve_o = (state_q == STARVE);
  assign victim_o = victim_q;

  assign rot_gnt     = |(req_o & gnt_i);
  assign per_wrap    = (per_q >= (cfg_period_i - PerWidth'(1)));
  assign victim_done = gnt_o[victim_q] | ~req_i[victim_q];

  always_comb begin
    starving = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      starving[i] = (cfg_thresh_i != '0) && (wait_q[i] >= cfg_thresh_i);
    end
  end

  tcdm_rr_pick #(
    .N (NumIn)
  ) u_pick (
    .req_i   (starving),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= NORMAL;
      rr_q     <= '0;
      per_q    <= '0;
      victim_q <= '0;
      ptr_q    <= '0;
      for (int i = 0; i < int'(NumIn); i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      // Wait counters run in both states, masked masters included.
      for (int i = 0; i < int'(NumIn); i++) begin
        if (!req_i[i] || gnt_o[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != '1) begin
          wait_q[i] <= wait_q[i] + WaitWidth'(1);
        end
      end

      unique case (state_q)
        NORMAL: begin
          if (mode_e'(cfg_mode_i) == ROT_ON_GNT) begin
            if (rot_gnt) rr_q <= rr_q + RrWidth'(1);
          end else if (cfg_period_i != '0) begin
            if (per_wrap) begin
              per_q <= '0;
              rr_q  <= rr_q + RrWidth'(1);
            end else begin
              per_q <= per_q + PerWidth'(1);
            end
          end
          if (pick_valid) begin
            state_q  <= STARVE;
            victim_q <= pick_idx;
          end
        end
        STARVE: begin
          // Advance the search pointer past the served master for fairness.
          if (victim_done) begin
            state_q <= NORMAL;
            ptr_q   <= victim_q + IdxWidth'(1);
          end
        end
        default: state_q <= NORMAL;
      endcase
    end
  end

endmodule
